hazard_unit_v2: RTL and testbench
=================================

# hazard_unit_v2

Parametrised hazard unit for the 5-stage MIPS pipeline, replacing the purely combinational detector at the ID stage. It detects load-use hazards and stalls for a configurable, counted number of cycles. It resolves branches and jumps in ID (BEQ, BNE, J, JR) using EX/MEM forwarding of the compared operands, then issues PC redirect and IF/ID flush. Optional saturating performance counters record stall and flush activity for the debug unit.

## Interface
- N_BITS, 32, data/address width
- N_BITS_REG, 5, register index width
- LOAD_LATENCY, 1, stall cycles per load-use hazard (>=1)
- CNT_BITS, 32, performance counter width

- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  pipeline advance enable (debug step); 0 freezes all state
- i_branch  in  3  000 none, 001 BEQ, 010 BNE, 011 J, 100 JR; others = none
- i_rs, i_rt  in  N_BITS_REG  ID source registers
- i_ID_EX_memRead  in  1  instruction in EX is a load
- i_ID_EX_rt  in  N_BITS_REG  load destination in EX
- i_wReg_ex, i_wReg_mem  in  1  EX/MEM instruction writes a register
- i_Alu_rt, i_Mem_rt  in  N_BITS_REG  EX/MEM destination register
- i_dato_leido_1, i_dato_leido_2  in  N_BITS  register-file read data (rs, rt)
- i_dato_salida_ALU, i_dato_salida_mem  in  N_BITS  EX ALU result, MEM writeback data
- i_jump_direction  in  N_BITS  precomputed branch/J target
- i_PC  in  N_BITS  sequential PC+4
- o_stall  out  1  hold PC and IF/ID
- o_bubble  out  1  zero ID/EX control
- o_flush  out  1  flush IF/ID
- o_PCSrc  out  1  select o_jump_direction
- o_jump_direction  out  N_BITS  next PC
- o_stall_count, o_flush_count  out  CNT_BITS  performance counters

## Operation
- FSM states: RUN, STALL. Down-counter width clog2(LOAD_LATENCY+1).
- Hazard match: index != 0 and equals the producer destination. Register 0 never hazards or forwards.
- Load-use in RUN: i_ID_EX_memRead and (i_rs or i_rt matches i_ID_EX_rt). Assert o_stall and o_bubble this cycle. If LOAD_LATENCY>1, go to STALL with counter = LOAD_LATENCY-1.
- STALL: o_stall=o_bubble=1. Counter decrements each enabled cycle. Return to RUN when it reaches 0 (last STALL cycle still stalls).
- Forwarding for compare operand A (rs) and B (rt), applied separately to each: EX match with i_wReg_ex and not a load gives ALU result. Otherwise MEM match with i_wReg_mem gives mem data. Otherwise register-file data. EX has priority.
- Branch resolution happens only in RUN with no load-use detected.
  - BEQ: taken if A==B.
  - BNE: taken if A!=B.
  - J: always taken, target i_jump_direction.
  - JR: always taken, target A.
- Taken: o_PCSrc=1, o_flush=1, o_jump_direction=target. Not taken / none: 0, 0, i_PC.
- Load-use has priority over branch resolution. A branch waiting on a load resolves on the first RUN cycle after the stall.
- i_enable=0: state, counter and perf counters hold. Combinational outputs are still driven.

## Timing
- o_stall, o_bubble, o_flush, o_PCSrc, o_jump_direction are combinational from the state and inputs, valid in the same cycle.
- Total stall per load-use = LOAD_LATENCY cycles.
- Branch redirect is 0-cycle: PC loads the target at the next edge, and the flush kills one instruction.
- While i_reset=1: all outputs 0, o_jump_direction=i_PC, state RUN, counter 0, perf counters 0. Reset mid-STALL aborts the stall immediately.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - o_stall_count increments on each enabled cycle with o_stall=1.
  - o_flush_count increments on each enabled cycle with o_flush=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: both outputs tied to 0 and no counter registers are synthesised.

## Test plan
- LOAD_LATENCY=1, EX load rt=5, ID rs=5 -> o_stall=o_bubble=1 for exactly 1 cycle, then RUN. Same with rs=0, rt=0 and i_ID_EX_rt=0 -> no stall.
- LOAD_LATENCY=3, load-use -> stall 3 cycles. i_enable=0 in cycle 2 extends the stall to 4 wall cycles. i_reset in cycle 2 -> o_stall=0 next cycle.
- BEQ, rs=3 matches EX ALU dest with ALU out 0x10, rt regfile 0x10 -> o_PCSrc=o_flush=1, o_jump_direction=i_jump_direction. With both EX and MEM matching rs, the ALU value is used.
- BNE, A=B=0x7 -> no redirect, o_jump_direction=i_PC. Then A=0x7, B=0x8 -> taken.
- JR, rs forwarded from MEM 0x400 -> o_jump_direction=0x400. Load-use plus BEQ in the same cycle -> stall first, branch resolves after.
- With HAZARD_PERF_CNT_EN, CNT_BITS=4: 20 stall cycles -> o_stall_count=15 (saturated). Without the macro -> both counters read 0.

Source files
------------

// File: rtl/hazard_unit_v2.sv
`default_nettype none
// ============================================================================
// hazard_unit_v2 : load-use stall counter, ID-stage branch/jump resolution
//                  with EX/MEM operand forwarding, optional perf counters.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall/flush saturating counters)
// Revision: 1.0
// ============================================================================
module hazard_unit_v2 #(
    parameter int N_BITS       = 32,
    parameter int N_BITS_REG   = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_BITS     = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [2:0]            i_branch,
    input  logic [N_BITS_REG-1:0] i_rs,
    input  logic [N_BITS_REG-1:0] i_rt,
    input  logic                  i_ID_EX_memRead,
    input  logic [N_BITS_REG-1:0] i_ID_EX_rt,
    input  logic                  i_wReg_ex,
    input  logic                  i_wReg_mem,
    input  logic [N_BITS_REG-1:0] i_Alu_rt,
    input  logic [N_BITS_REG-1:0] i_Mem_rt,
    input  logic [N_BITS-1:0]     i_dato_leido_1,
    input  logic [N_BITS-1:0]     i_dato_leido_2,
    input  logic [N_BITS-1:0]     i_dato_salida_ALU,
    input  logic [N_BITS-1:0]     i_dato_salida_mem,
    input  logic [N_BITS-1:0]     i_jump_direction,
    input  logic [N_BITS-1:0]     i_PC,
    output logic                  o_stall,
    output logic                  o_bubble,
    output logic                  o_flush,
    output logic                  o_PCSrc,
    output logic [N_BITS-1:0]     o_jump_direction,
    output logic [CNT_BITS-1:0]   o_stall_count,
    output logic [CNT_BITS-1:0]   o_flush_count
);

    localparam int            CW       = $clog2(LOAD_LATENCY + 1);
    localparam logic [CW-1:0] C_RELOAD = CW'(LOAD_LATENCY - 1);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            w_load_use;
    logic            w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
    logic [N_BITS-1:0] w_op_a, w_op_b, w_target;
    logic            w_taken;

    assign w_load_use = i_ID_EX_memRead && (i_ID_EX_rt != '0) &&
                        ((i_rs == i_ID_EX_rt) || (i_rt == i_ID_EX_rt));

    // A load in EX has no result yet, so it must not forward its ALU value.
    assign w_ex_rs  = (i_rs != '0) && i_wReg_ex && !i_ID_EX_memRead && (i_rs == i_Alu_rt);
    assign w_ex_rt  = (i_rt != '0) && i_wReg_ex && !i_ID_EX_memRead && (i_rt == i_Alu_rt);
    assign w_mem_rs = (i_rs != '0) && i_wReg_mem && (i_rs == i_Mem_rt);
    assign w_mem_rt = (i_rt != '0) && i_wReg_mem && (i_rt == i_Mem_rt);

    assign w_op_a = w_ex_rs ? i_dato_salida_ALU : (w_mem_rs ? i_dato_salida_mem : i_dato_leido_1);
    assign w_op_b = w_ex_rt ? i_dato_salida_ALU : (w_mem_rt ? i_dato_salida_mem : i_dato_leido_2);

    always_comb begin
        w_taken  = 1'b0;
        w_target = i_jump_direction;
        case (i_branch)
            3'b001:  w_taken = (w_op_a == w_op_b);
            3'b010:  w_taken = (w_op_a != w_op_b);
            3'b011:  w_taken = 1'b1;
            3'b100: begin
                w_taken  = 1'b1;
                w_target = w_op_a;
            end
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        o_stall          = 1'b0;
        o_bubble         = 1'b0;
        o_flush          = 1'b0;
        o_PCSrc          = 1'b0;
        o_jump_direction = i_PC;
        if (!i_reset) begin
            if (r_state == ST_STALL || w_load_use) begin
                o_stall  = 1'b1;
                o_bubble = 1'b1;
            end else if (w_taken) begin
                o_flush          = 1'b1;
                o_PCSrc          = 1'b1;
                o_jump_direction = w_target;
            end
        end
    end

    // The detection cycle is the first stall cycle; STALL covers the rest.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else if (i_enable) begin
            case (r_state)
                ST_RUN: begin
                    if (w_load_use && (LOAD_LATENCY > 1)) begin
                        r_state <= ST_STALL;
                        r_cnt   <= C_RELOAD;
                    end
                end
                ST_STALL: begin
                    if (r_cnt <= CW'(1)) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_BITS-1:0] r_stall_count, r_flush_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (i_enable) begin
            if (o_stall && (r_stall_count != '1)) r_stall_count <= r_stall_count + CNT_BITS'(1);
            if (o_flush && (r_flush_count != '1)) r_flush_count <= r_flush_count + CNT_BITS'(1);
        end
    end

    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;
`else
    assign o_stall_count = '0;
    assign o_flush_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_v2.sv
`timescale 1ns/1ps
module tb_hazard_unit_v2;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, en = 1'b1, mr = 1'b0, wex = 1'b0, wmem = 1'b0;
    logic [2:0]  br = '0;
    logic [4:0]  rs = '0, rt = '0, exrt = '0, alurt = '0, memrt = '0;
    logic [31:0] d1 = '0, d2 = '0, alu = '0, mem = '0, jt = '0, pc = '0;

    logic [1:0]  o_st, o_bu, o_fl, o_pc;
    logic [31:0] o_jd [2];
    logic [3:0]  o_sc [2];
    logic [3:0]  o_fc [2];

    hazard_unit_v2 #(.N_BITS(32), .N_BITS_REG(5), .LOAD_LATENCY(1), .CNT_BITS(4)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_branch(br), .i_rs(rs), .i_rt(rt),
        .i_ID_EX_memRead(mr), .i_ID_EX_rt(exrt), .i_wReg_ex(wex), .i_wReg_mem(wmem),
        .i_Alu_rt(alurt), .i_Mem_rt(memrt), .i_dato_leido_1(d1), .i_dato_leido_2(d2),
        .i_dato_salida_ALU(alu), .i_dato_salida_mem(mem), .i_jump_direction(jt), .i_PC(pc),
        .o_stall(o_st[0]), .o_bubble(o_bu[0]), .o_flush(o_fl[0]), .o_PCSrc(o_pc[0]),
        .o_jump_direction(o_jd[0]), .o_stall_count(o_sc[0]), .o_flush_count(o_fc[0]));

    hazard_unit_v2 #(.N_BITS(32), .N_BITS_REG(5), .LOAD_LATENCY(3), .CNT_BITS(4)) u_dut3 (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_branch(br), .i_rs(rs), .i_rt(rt),
        .i_ID_EX_memRead(mr), .i_ID_EX_rt(exrt), .i_wReg_ex(wex), .i_wReg_mem(wmem),
        .i_Alu_rt(alurt), .i_Mem_rt(memrt), .i_dato_leido_1(d1), .i_dato_leido_2(d2),
        .i_dato_salida_ALU(alu), .i_dato_salida_mem(mem), .i_jump_direction(jt), .i_PC(pc),
        .o_stall(o_st[1]), .o_bubble(o_bu[1]), .o_flush(o_fl[1]), .o_PCSrc(o_pc[1]),
        .o_jump_direction(o_jd[1]), .o_stall_count(o_sc[1]), .o_flush_count(o_fc[1]));

    typedef struct packed {
        logic [1:0]       stall, bubble, flush, pcsrc;
        logic [1:0][31:0] jd;
        logic [1:0][3:0]  sc, fc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0, fails = 0, cycle = 0;
    int   rem [2] = '{0, 0};
    int   scnt[2] = '{0, 0};
    int   fcnt[2] = '{0, 0};

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
        if (r != 0 && wex && !mr && r == alurt) return alu;
        if (r != 0 && wmem && r == memrt)       return mem;
        return rf;
    endfunction

    // Reference: remaining stall cycles per instance, plain rule evaluation.
    task automatic push_expect();
        exp_t        e;
        logic [31:0] a, b, tgt;
        logic        lu, tk, stl;
        int          lat;
        a   = fwd(rs, d1);
        b   = fwd(rt, d2);
        lu  = mr && exrt != 0 && (rs == exrt || rt == exrt);
        tgt = jt;
        tk  = 1'b0;
        case (br)
            3'd1: tk = (a == b);
            3'd2: tk = (a != b);
            3'd3: tk = 1'b1;
            3'd4: begin tk = 1'b1; tgt = a; end
            default: tk = 1'b0;
        endcase
        e = '0;
        for (int i = 0; i < 2; i++) begin
            lat = (i == 0) ? 1 : 3;
            e.sc[i] = PERF ? 4'(scnt[i]) : 4'd0;
            e.fc[i] = PERF ? 4'(fcnt[i]) : 4'd0;
            if (rst) begin
                e.jd[i] = pc;
                rem[i] = 0; scnt[i] = 0; fcnt[i] = 0;
            end else begin
                stl = (rem[i] > 0) || lu;
                e.stall[i]  = stl;
                e.bubble[i] = stl;
                e.flush[i]  = !stl && tk;
                e.pcsrc[i]  = !stl && tk;
                e.jd[i]     = (!stl && tk) ? tgt : pc;
                if (en) begin
                    if (rem[i] > 0) rem[i]--;
                    else if (lu)    rem[i] = lat - 1;
                    if (stl && scnt[i] < 15)         scnt[i]++;
                    if (!stl && tk && fcnt[i] < 15)  fcnt[i]++;
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic e, input logic [2:0] b,
                       input logic [4:0] s, input logic [4:0] t, input logic m,
                       input logic [4:0] x, input logic we, input logic [4:0] ar,
                       input logic wm, input logic [4:0] mrg,
                       input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] aa, input logic [31:0] am);
        @(posedge clk); #1;
        rst = r; en = e; br = b; rs = s; rt = t; mr = m; exrt = x;
        wex = we; alurt = ar; wmem = wm; memrt = mrg;
        d1 = a1; d2 = a2; alu = aa; mem = am;
        jt = $urandom; pc = $urandom & 32'hFFFF_FFFC;
        push_expect();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cycle++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < 2; i++) begin
                    tests++;
                    if (o_st[i] !== e.stall[i] || o_bu[i] !== e.bubble[i] ||
                        o_fl[i] !== e.flush[i] || o_pc[i] !== e.pcsrc[i] ||
                        o_jd[i] !== e.jd[i] || o_sc[i] !== e.sc[i] || o_fc[i] !== e.fc[i]) begin
                        fails++;
                        $display("FAIL outputs lat%0d cyc%0d: got st=%b bu=%b fl=%b pcs=%b jd=%h sc=%0d fc=%0d want st=%b bu=%b fl=%b pcs=%b jd=%h sc=%0d fc=%0d",
                                 (i == 0) ? 1 : 3, cycle, o_st[i], o_bu[i], o_fl[i], o_pc[i], o_jd[i],
                                 o_sc[i], o_fc[i], e.stall[i], e.bubble[i], e.flush[i], e.pcsrc[i],
                                 e.jd[i], e.sc[i], e.fc[i]);
                    end
                end
            end
        end
    end

    initial begin : driver
        repeat (2) @(posedge clk);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);           // reset state
        cyc(0, 1, 0, 5, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);           // load-use rs=5
        idle(3);
        cyc(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);           // r0 never hazards
        cyc(0, 1, 1, 3, 4, 0, 0, 1, 3, 0, 0, 0, 32'h10, 32'h10, 0); // BEQ via EX fwd
        cyc(0, 1, 1, 3, 4, 0, 0, 1, 3, 1, 3, 0, 32'h10, 32'h10, 32'h20); // EX beats MEM
        cyc(0, 1, 2, 1, 2, 0, 0, 0, 0, 0, 0, 7, 7, 0, 0);           // BNE equal
        cyc(0, 1, 2, 1, 2, 0, 0, 0, 0, 0, 0, 7, 8, 0, 0);           // BNE differ
        cyc(0, 1, 4, 6, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 32'h400);     // JR from MEM
        cyc(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);           // J
        cyc(0, 1, 1, 3, 4, 1, 3, 0, 0, 0, 0, 1, 1, 0, 0);           // load-use + BEQ
        for (int k = 0; k < 4; k++) cyc(0, 1, 1, 3, 4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc(0, 1, 0, 5, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);           // stall, enable low mid
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        cyc(0, 1, 0, 5, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);           // stall, reset mid
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int k = 0; k < 20; k++) cyc(0, 1, 0, 5, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
                32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
        end
        @(negedge clk); #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
